// File: rtl/alu_result_fifo.sv
// Two-entry skid FIFO for alu32 results with registered head outputs
// and overflow statistics (sticky flag plus saturating counter).
module alu_result_fifo #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_overflow,
  input  logic             in_zero,
  input  logic             in_negative,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             out_negative,
  input  logic             out_ready,
  input  logic             clear_sticky,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
    logic        zero;
    logic        neg;
  } entry_t;

  entry_t     mem [2];
  entry_t     in_e;
  entry_t     head_q;
  entry_t     head_d;
  logic       rd_ptr;
  logic       wr_ptr;
  logic       rd_nxt;
  logic [1:0] occ;
  logic [1:0] occ_nxt;
  logic       push;
  logic       pop;
  logic       ovf_push;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  assign in_ready  = !occ[1] && !reset;
  assign out_valid = (occ != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign ovf_push  = push && in_overflow;
  assign in_e      = '{data: in_data, ovf: in_overflow,
                       zero: in_zero, neg: in_negative};

  always_comb begin
    rd_nxt  = rd_ptr ^ pop;
    occ_nxt = occ;
    unique case ({push, pop})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  // Next head may be the entry being written this very cycle.
  always_comb begin
    head_d = head_q;
    if (occ_nxt != 2'd0) begin
      if (push && (wr_ptr == rd_nxt)) head_d = in_e;
      else                            head_d = mem[rd_nxt];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
      head_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_e;
        wr_ptr      <= ~wr_ptr;
      end
      rd_ptr <= rd_nxt;
      occ    <= occ_nxt;
      head_q <= head_d;
    end
  end

  assign out_data     = head_q.data;
  assign out_overflow = head_q.ovf;
  assign out_zero     = head_q.zero;
  assign out_negative = head_q.neg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else begin
      if (ovf_push)          ovf_sticky <= 1'b1;
      else if (clear_sticky) ovf_sticky <= 1'b0;
      if (clear_sticky)
        ovf_count <= ovf_push ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
      else if (ovf_push && ovf_count != CNT_MAX)
        ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo; a CNT_W=2 copy shares the
// stimulus to exercise counter saturation.
module tb_alu_result_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_overflow;
  logic        in_zero;
  logic        in_negative;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_overflow;
  logic        out_zero;
  logic        out_negative;
  logic        out_ready;
  logic        clear_sticky;
  logic        ovf_sticky;
  logic [7:0]  ovf_count;

  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_data2;
  logic        out_overflow2;
  logic        out_zero2;
  logic        out_negative2;
  logic        ovf_sticky2;
  logic [1:0]  ovf_count2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_result_fifo #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data),
    .in_overflow(in_overflow), .in_zero(in_zero),
    .in_negative(in_negative), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_overflow(out_overflow), .out_zero(out_zero),
    .out_negative(out_negative), .out_ready(out_ready),
    .clear_sticky(clear_sticky), .ovf_sticky(ovf_sticky),
    .ovf_count(ovf_count)
  );

  alu_result_fifo #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data),
    .in_overflow(in_overflow), .in_zero(in_zero),
    .in_negative(in_negative), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2),
    .out_overflow(out_overflow2), .out_zero(out_zero2),
    .out_negative(out_negative2), .out_ready(out_ready),
    .clear_sticky(clear_sticky), .ovf_sticky(ovf_sticky2),
    .ovf_count(ovf_count2)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] d,
                       logic o, logic z, logic n);
    in_valid    = v;
    in_data     = d;
    in_overflow = o;
    in_zero     = z;
    in_negative = n;
  endtask

  initial begin
    reset        = 1'b1;
    out_ready    = 1'b0;
    clear_sticky = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_valid", 32'(out_valid), 32'd0);

    // single push, popped immediately
    out_ready = 1'b1;
    drive(1'b1, 32'h0000000C, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("p1_valid", 32'(out_valid), 32'd1);
    chk("p1_data", out_data, 32'h0000000C);
    chk("p1_zero", 32'(out_zero), 32'd0);
    chk("p1_neg", 32'(out_negative), 32'd0);
    step();
    chk("p1_empty", 32'(out_valid), 32'd0);
    chk("p1_hold", out_data, 32'h0000000C);

    // fill with backpressure, stall third
    out_ready = 1'b0;
    drive(1'b1, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'h00000010, 1'b0, 1'b0, 1'b0);
    chk("f1_ready", 32'(in_ready), 32'd1);
    step();
    drive(1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0);
    chk("f2_full", 32'(in_ready), 32'd0);
    chk("f2_head", out_data, 32'hFFFFFFFD);
    chk("f2_neg", 32'(out_negative), 32'd1);
    step();
    chk("stall_head", out_data, 32'hFFFFFFFD);
    chk("stall_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    chk("drain_10", out_data, 32'h00000010);
    chk("drain_neg", 32'(out_negative), 32'd0);
    // push+pop at occupancy 1
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("pp_head", out_data, 32'h00000013);
    chk("pp_valid", 32'(out_valid), 32'd1);
    chk("pp_ready", 32'(in_ready), 32'd1);
    step();
    chk("pp_empty", 32'(out_valid), 32'd0);
    chk("no_ovf", 32'(ovf_count), 32'd0);

    // overflow statistics
    drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    step();
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("ovf_cnt3", 32'(ovf_count), 32'd3);
    chk("ovf_sticky", 32'(ovf_sticky), 32'd1);
    chk("ovf_zero", 32'(out_zero), 32'd1);
    chk("ovf_flag", 32'(out_overflow), 32'd1);
    clear_sticky = 1'b1;
    drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("clr_push_cnt", 32'(ovf_count), 32'd1);
    chk("clr_push_stk", 32'(ovf_sticky), 32'd1);
    step();
    clear_sticky = 1'b0;
    chk("clr_cnt", 32'(ovf_count), 32'd0);
    chk("clr_stk", 32'(ovf_sticky), 32'd0);

    // full FIFO ignores further overflow pushes
    out_ready = 1'b0;
    drive(1'b1, 32'h0000000A, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0000000B, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0000000E, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("stall_cnt", 32'(ovf_count), 32'd2);
    chk("stall_hd", out_data, 32'h0000000A);

    // asynchronous reset with two entries held
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_cnt", 32'(ovf_count), 32'd0);
    chk("ar_data", out_data, 32'h0);
    chk("ar_ready", 32'(in_ready), 32'd0);
    #1 reset = 1'b0;
    #1;
    chk("ar_rel_ready", 32'(in_ready), 32'd1);
    chk("ar_rel_valid", 32'(out_valid), 32'd0);
    step();
    chk("ar_empty", 32'(out_valid), 32'd0);

    // saturation with CNT_W=2
    out_ready = 1'b1;
    drive(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_w2", 32'(ovf_count2), 32'd3);
    chk("sat_w8", 32'(ovf_count), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 The block SHALL have parameter `CNT_W`, default 8: width of the overflow event counter.
REQ-002 The block SHALL have port `clk`: input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port `reset`: input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port `in_valid`: input, 1 bit; the upstream alu32 result is valid this cycle.
REQ-005 The block SHALL have port `in_data`: input, 32 bits; the alu32 `out` value.
REQ-006 The block SHALL have ports `in_overflow`, `in_zero`, `in_negative`: input, 1 bit each; the alu32 flags.
REQ-007 The block SHALL have port `in_ready`: output, 1 bit; the block can accept an entry this cycle.
REQ-008 The block SHALL have port `out_valid`: output, 1 bit; the head entry is presented.
REQ-009 The block SHALL have port `out_data`: output, 32 bits; the head entry data.
REQ-010 The block SHALL have ports `out_overflow`, `out_zero`, `out_negative`: output, 1 bit each; the head entry flags.
REQ-011 The block SHALL have port `out_ready`: input, 1 bit; downstream accepts the head this cycle.
REQ-012 The block SHALL have port `clear_sticky`: input, 1 bit; synchronous clear of the overflow status.
REQ-013 The block SHALL have port `ovf_sticky`: output, 1 bit; at least one overflowed result was accepted since the last clear.
REQ-014 The block SHALL have port `ovf_count`: output, `CNT_W` bits; saturating count of accepted overflowed results.

Function
REQ-015 The block SHALL store entries in a 2-entry FIFO; each entry is 35 bits {data, overflow, zero, negative}, stored unmodified.
REQ-016 A push SHALL occur when `in_valid` && `in_ready`; a pop SHALL occur when `out_valid` && `out_ready`.
REQ-017 `in_ready` SHALL equal (occupancy < 2) && !`reset`; `out_valid` SHALL equal (occupancy != 0).
REQ-018 The `out_*` ports SHALL be driven from registered storage at the head pointer; there SHALL be no combinational path from `in_*` to `out_*`.
REQ-019 Latency SHALL be 1 cycle: an entry pushed at edge N is presented with `out_valid`=1 after edge N.
REQ-020 While `out_valid`=1 and `out_ready`=0, all `out_*` SHALL remain stable.
REQ-021 Read and write pointers SHALL be 1 bit each and SHALL wrap modulo 2; occupancy SHALL be 2 bits with range 0..2.
REQ-022 Push and pop in the same cycle at occupancy 1: occupancy SHALL stay 1 and the pushed entry SHALL become the head.
REQ-023 At occupancy 2, a push SHALL NOT be possible (`in_ready`=0), and a pop SHALL reduce occupancy to 1.
REQ-024 A pop at occupancy 0 SHALL NOT be possible (`out_valid`=0), and `out_ready` SHALL be ignored.
REQ-025 When `out_valid`=0, `out_*` SHALL hold their last values, or 0 after reset.
REQ-026 `ovf_sticky` SHALL be set on a push with `in_overflow`=1 and cleared by `clear_sticky`=1; when both occur in the same cycle, set wins.
REQ-027 `ovf_count` SHALL increment by 1 on each push with `in_overflow`=1 and saturate at 2^`CNT_W`-1.
REQ-028 `clear_sticky` SHALL zero `ovf_count`; if an overflow push occurs in the same cycle, `ovf_count` SHALL become 1.
REQ-029 `in_valid`=1 while `in_ready`=0 SHALL have no effect on FIFO state or the overflow statistics.

Reset
REQ-030 Asserting `reset` SHALL immediately, without waiting for a clock edge, set occupancy, pointers, `out_valid`, `out_data`, `out_*` flags, `ovf_sticky` and `ovf_count` to 0, and drive `in_ready`=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries.
REQ-032 In the first cycle after `reset` deasserts, `in_ready` SHALL be 1 and `out_valid` SHALL be 0.

Verification
REQ-033 Push 0x0000000C (flags 000) with `out_ready`=1 -> next cycle `out_valid`=1, `out_data`=0x0000000C, zero=0, negative=0; popped the same cycle, then `out_valid`=0.
REQ-034 With `out_ready`=0, push 0xFFFFFFFD (negative=1), 0x00000010, then 0x00000013 -> `in_ready`=0 after the second push, the third stalls; raise `out_ready` -> outputs 0xFFFFFFFD, 0x00000010, 0x00000013 in order, nothing lost or duplicated.
REQ-035 At occupancy 1 (head 0x10), push 0x13 and pop in the same cycle -> occupancy 1, head 0x00000013.
REQ-036 Push three entries with overflow=1 (0x00000000, zero=1) -> `ovf_count`=3, `ovf_sticky`=1; `clear_sticky` plus an overflow push in the same cycle -> count 1, sticky 1; `clear_sticky` alone -> 0, 0.
REQ-037 With `CNT_W`=2, push 4 overflowed entries -> `ovf_count` holds at 3.
REQ-038 With 2 entries held, assert `reset` between clock edges -> `out_valid`=0 and `ovf_count`=0 before the next edge; after release, occupancy is 0.
